lane_stream_tx: RTL

Transmit side of the column-parity lane interface. On `start` it walks lane indices 0..24 of the 5x5 state memory, issues synchronous reads, and streams each lane with its (x, y) coordinates over a valid/ready handshake to the parity datapath. It tolerates arbitrary downstream backpressure without dropping or duplicating lanes. It sits between the state RAM and the 25-lane counting receiver, and completes exactly 25 transfers per frame.

---
 rtl/lane_stream_if.sv | 28 ++
 rtl/lane_stream_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lane_stream_if.sv
// Lane stream bundle: state RAM read port, downstream lane handshake and frame control/status.
// master = the transmitter, slave = the RAM/receiver environment around it.
interface lane_stream_if #(
  parameter int W = 64
);
  logic         start;
  logic         mem_ren;
  logic [4:0]   mem_raddr;
  logic [W-1:0] mem_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_lane;
  logic [2:0]   out_x;
  logic [2:0]   out_y;
  logic         out_last;
  logic         busy;
  logic         done;

  modport master (
    input  start, mem_rdata, out_ready,
    output mem_ren, mem_raddr, out_valid, out_lane, out_x, out_y, out_last, busy, done
  );

  modport slave (
    output start, mem_rdata, out_ready,
    input  mem_ren, mem_raddr, out_valid, out_lane, out_x, out_y, out_last, busy, done
  );
endinterface

// File: rtl/lane_stream_tx.sv
// Streams the 25 lanes of the 5x5 state RAM, tagged with (x, y), over a valid/ready link.
// A 2-entry fall-through FIFO plus a credit check on issue absorbs any backpressure.
module lane_stream_tx #(
  parameter int W = 64
) (
  input  logic          clk,
  input  logic          rst,
  lane_stream_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  typedef struct packed {
    logic [W-1:0] lane;
    logic [2:0]   x;
    logic [2:0]   y;
    logic         last;
  } entry_t;

  state_t     state_reg;
  logic [4:0] rd_idx_reg;
  logic [2:0] rd_x_reg;
  logic [2:0] rd_y_reg;
  logic       busy_reg;
  logic       done_reg;

  logic       inflight_reg;
  logic [2:0] ifl_x_reg;
  logic [2:0] ifl_y_reg;
  logic       ifl_last_reg;

  entry_t     fifo_mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  logic       issue;
  logic       fifo_empty;
  logic       valid;
  logic       xfer;
  logic       bypass;
  logic       fifo_wr;
  logic       fifo_rd;
  entry_t     arriving;
  entry_t     head;

  assign fifo_empty = (count_reg == 2'd0);
  assign issue      = (state_reg == ISSUE) &&
                      (({1'b0, count_reg} + {2'b00, inflight_reg}) < 3'd2);

  // Returning data is visible on the outputs in the cycle it arrives when the FIFO is empty.
  assign arriving = {bus.mem_rdata, ifl_x_reg, ifl_y_reg, ifl_last_reg};
  assign head     = fifo_empty ? arriving : fifo_mem[rd_ptr_reg];
  assign valid    = !fifo_empty || inflight_reg;
  assign xfer     = valid && bus.out_ready;
  assign bypass   = fifo_empty && xfer;
  assign fifo_wr  = inflight_reg && !bypass;
  assign fifo_rd  = !fifo_empty && xfer;

  assign bus.mem_ren   = issue;
  assign bus.mem_raddr = issue ? rd_idx_reg : 5'd0;
  assign bus.out_valid = valid;
  assign bus.out_lane  = valid ? head.lane : '0;
  assign bus.out_x     = valid ? head.x : 3'd0;
  assign bus.out_y     = valid ? head.y : 3'd0;
  assign bus.out_last  = valid && head.last;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rd_idx_reg <= 5'd0;
      rd_x_reg   <= 3'd0;
      rd_y_reg   <= 3'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          rd_idx_reg <= 5'd0;
          rd_x_reg   <= 3'd0;
          rd_y_reg   <= 3'd0;
          if (bus.start) begin
            state_reg <= ISSUE;
            busy_reg  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (rd_idx_reg == 5'd24) begin
              state_reg <= DRAIN;
              rd_x_reg  <= 3'd0;
              rd_y_reg  <= 3'd0;
            end else begin
              rd_idx_reg <= rd_idx_reg + 5'd1;
              if (rd_x_reg == 3'd4) begin
                rd_x_reg <= 3'd0;
                rd_y_reg <= rd_y_reg + 3'd1;
              end else begin
                rd_x_reg <= rd_x_reg + 3'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (xfer && head.last) begin
            state_reg <= FIN;
            done_reg  <= 1'b1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Coordinates ride alongside the read so the returning word is tagged on arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      ifl_x_reg    <= 3'd0;
      ifl_y_reg    <= 3'd0;
      ifl_last_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        ifl_x_reg    <= rd_x_reg;
        ifl_y_reg    <= rd_y_reg;
        ifl_last_reg <= (rd_idx_reg == 5'd24);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (fifo_wr) wr_ptr_reg <= ~wr_ptr_reg;
      if (fifo_rd) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, fifo_wr} - {1'b0, fifo_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_reg] <= arriving;
  end
endmodule
